debug_host: RTL and testbench

Command-driven debug controller that drives the CPU core's debug/load port: `debug`, `clk_ld`, `addr`, `din`, `we_im`, `we_dm`. It reads back `dout_im`, `dout_dm`, `dout_rf` and `PC`. Commands arrive as a byte stream from the board UART receiver, and responses leave as a byte stream to the UART transmitter. The block sits between the UART and the CPU top. It is the host-side initiator for the core's load/inspect interface.

---
 rtl/debug_host_if.sv | 30 +++
 rtl/debug_host.sv | 227 ++++++++++++++++++++++
 tb/tb_debug_host.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_host_if.sv
// Byte-stream command/response link plus the core's debug load/inspect port.
// The master modport is the debug_host side; the slave modport is the UART/core environment.
interface debug_host_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        debug;
  logic        clk_ld;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;
  logic [31:0] dout_im;
  logic [31:0] dout_dm;
  logic [31:0] dout_rf;
  logic [31:0] pc;

  modport master (
    input  rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf, pc,
    output rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din, we_im, we_dm
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf, pc,
    input  rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din, we_im, we_dm
  );
endinterface

// File: rtl/debug_host.sv
// Command-driven debug controller: parses UART command bytes, drives the core's
// load/inspect port with a single clk_ld pulse per write/step, and streams responses back.
module debug_host (
  input  logic         clk,
  input  logic         rst,
  debug_host_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_EXEC, S_CLK_HI, S_CLK_LO, S_CAPT, S_SEND
  } state_t;

  localparam logic [7:0] OP_WIM   = 8'h01;
  localparam logic [7:0] OP_WDM   = 8'h02;
  localparam logic [7:0] OP_RIM   = 8'h03;
  localparam logic [7:0] OP_RDM   = 8'h04;
  localparam logic [7:0] OP_RRF   = 8'h05;
  localparam logic [7:0] OP_STEP  = 8'h06;
  localparam logic [7:0] OP_RUN   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'h08;
  localparam logic [7:0] RESP_OK  = 8'hAA;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  argc_q, argc_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] args_q, args_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        debug_q, debug_d;
  logic        clk_ld_q, clk_ld_d;
  logic        we_im_q, we_im_d;
  logic        we_dm_q, we_dm_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;

  logic rx_fire;
  logic tx_fire;
  logic is_write;

  assign rx_fire  = bus.rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & bus.tx_ready;
  assign is_write = (op_q == OP_WIM) || (op_q == OP_WDM);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    argc_d   = argc_q;
    idx_d    = idx_q;
    args_d   = args_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    debug_d  = debug_q;
    clk_ld_d = clk_ld_q;
    we_im_d  = we_im_q;
    we_dm_d  = we_dm_q;
    addr_d   = addr_q;
    din_d    = din_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          op_d  = bus.rx_data;
          idx_d = 3'd0;
          case (bus.rx_data)
            OP_WIM, OP_WDM: begin
              argc_d  = 3'd6;
              state_d = S_ARGS;
            end
            OP_RIM, OP_RDM, OP_RRF: begin
              argc_d  = 3'd2;
              state_d = S_ARGS;
            end
            // debug flips on acceptance so the core sees it one cycle later
            OP_RUN: begin
              debug_d = 1'b0;
              state_d = S_EXEC;
            end
            OP_HALT: begin
              debug_d = 1'b1;
              state_d = S_EXEC;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end

      S_ARGS: begin
        if (rx_fire) begin
          args_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
          idx_d = idx_q + 3'd1;
          if (idx_q == argc_q - 3'd1) begin
            state_d = S_EXEC;
            // Loading addr/din/we here puts them on the port in the EXEC cycle;
            // rejected writes leave the port untouched.
            if (!is_write) begin
              addr_d = args_d[9:0];
            end else if (debug_q) begin
              addr_d  = args_d[9:0];
              din_d   = args_d[47:16];
              we_im_d = (op_q == OP_WIM);
              we_dm_d = (op_q == OP_WDM);
            end
          end
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_WIM, OP_WDM, OP_STEP: begin
            if (debug_q) begin
              clk_ld_d = 1'b1;
              state_d  = S_CLK_HI;
            end else begin
              shift_d = {24'd0, RESP_ERR};
              cnt_d   = 3'd1;
              state_d = S_SEND;
            end
          end
          OP_RIM, OP_RDM, OP_RRF: state_d = S_CAPT;
          OP_RUN, OP_HALT: begin
            shift_d = {24'd0, RESP_OK};
            cnt_d   = 3'd1;
            state_d = S_SEND;
          end
          default: begin
            shift_d = {24'd0, RESP_ERR};
            cnt_d   = 3'd1;
            state_d = S_SEND;
          end
        endcase
      end

      S_CLK_HI: begin
        clk_ld_d = 1'b0;
        we_im_d  = 1'b0;
        we_dm_d  = 1'b0;
        state_d  = S_CLK_LO;
      end

      S_CLK_LO: begin
        if (is_write) begin
          shift_d = {24'd0, RESP_OK};
          cnt_d   = 3'd1;
          state_d = S_SEND;
        end else begin
          state_d = S_CAPT;
        end
      end

      S_CAPT: begin
        case (op_q)
          OP_RIM:  shift_d = bus.dout_im;
          OP_RDM:  shift_d = bus.dout_dm;
          OP_RRF:  shift_d = bus.dout_rf;
          default: shift_d = bus.pc;
        endcase
        cnt_d   = 3'd4;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (tx_fire) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  assign rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARGS);
  assign tx_valid_d = (state_d == S_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 8'd0;
      argc_q     <= 3'd0;
      idx_q      <= 3'd0;
      args_q     <= 48'd0;
      shift_q    <= 32'd0;
      cnt_q      <= 3'd0;
      debug_q    <= 1'b1;
      clk_ld_q   <= 1'b0;
      we_im_q    <= 1'b0;
      we_dm_q    <= 1'b0;
      addr_q     <= 10'd0;
      din_q      <= 32'd0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      argc_q     <= argc_d;
      idx_q      <= idx_d;
      args_q     <= args_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      debug_q    <= debug_d;
      clk_ld_q   <= clk_ld_d;
      we_im_q    <= we_im_d;
      we_dm_q    <= we_dm_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_data  = shift_q[7:0];
  assign bus.tx_valid = tx_valid_q;
  assign bus.debug    = debug_q;
  assign bus.clk_ld   = clk_ld_q;
  assign bus.addr     = {22'd0, addr_q};
  assign bus.din      = din_q;
  assign bus.we_im    = we_im_q;
  assign bus.we_dm    = we_dm_q;
endmodule

// File: tb/tb_debug_host.sv
// Self-checking bench for debug_host: directed scenarios then random commands,
// each compared against a command-level reference model of memories, pc and debug mode.
module tb_debug_host;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_host_if bus();

  debug_host dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // ---------------- core environment ----------------
  logic [31:0] im [1024];
  logic [31:0] dm [1024];
  logic [31:0] rf [32];
  int          pulse_total = 0;
  logic [31:0] pc_base = 32'd0;
  int          pulse_mark = 0;

  initial begin : core_env
    for (int i = 0; i < 1024; i++) begin
      im[i] = $urandom;
      dm[i] = $urandom;
    end
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[3] = 32'd7;
    forever begin
      @(posedge bus.clk_ld);
      if (bus.we_im) im[bus.addr[9:0]] = bus.din;
      if (bus.we_dm) dm[bus.addr[9:0]] = bus.din;
      pulse_total++;
    end
  end

  assign bus.dout_im = im[bus.addr[9:0]];
  assign bus.dout_dm = dm[bus.addr[9:0]];
  assign bus.dout_rf = rf[bus.addr[4:0]];
  assign bus.pc      = pc_base + 32'(pulse_total - pulse_mark) * 32'd4;

  // ---------------- sink back-pressure ----------------
  logic force_stall = 1'b0;
  initial begin : tx_sink
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         hold_viol = 0, excl_viol = 0, lddbg_viol = 0;
  int         we_im_cyc = 0, we_dm_cyc = 0;
  int         last_rx_cyc = 0, first_tx_cyc = 0;
  logic       tx_seen = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && (!bus.tx_valid || bus.tx_data != prev_data)) hold_viol <= hold_viol + 1;
      if (bus.we_im && bus.we_dm) excl_viol <= excl_viol + 1;
      if (bus.clk_ld && !bus.debug) lddbg_viol <= lddbg_viol + 1;
      stall_prev <= bus.tx_valid & ~bus.tx_ready;
      prev_data  <= bus.tx_data;
      if (bus.rx_valid && bus.rx_ready) begin
        last_rx_cyc <= cyc;
        tx_seen     <= 1'b0;
      end else if (bus.tx_valid && !tx_seen) begin
        first_tx_cyc <= cyc;
        tx_seen      <= 1'b1;
      end
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.we_im) we_im_cyc <= we_im_cyc + 1;
      if (bus.we_dm) we_dm_cyc <= we_dm_cyc + 1;
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_im [1024];
  logic [31:0] ref_dm [1024];
  logic [31:0] ref_rf [32];
  logic [31:0] ref_pc;
  logic        ref_debug;

  // Caller must be at posedge+1 when calling.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_word(inout bq_t q, input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic run_cmd(input bq_t cmd, input bit stall);
    bq_t         exp;
    logic [7:0]  op;
    logic [15:0] a16;
    int          a;
    logic [31:0] d;
    int          exp_pulse, exp_lat, exp_wim, exp_wdm;
    int          base, p0, wi0, wd0, hv0, ev0, lv0, n;
    bit          stalled;

    op = cmd[0];
    a  = 0;
    d  = 32'd0;
    if (cmd.size() >= 3) begin
      a16 = {cmd[2], cmd[1]};
      a   = int'(a16) % 1024;
    end
    if (cmd.size() >= 7) d = {cmd[6], cmd[5], cmd[4], cmd[3]};
    exp_pulse = 0; exp_lat = 2; exp_wim = 0; exp_wdm = 0;
    case (op)
      8'h01, 8'h02: begin
        if (ref_debug) begin
          if (op == 8'h01) begin ref_im[a] = d; exp_wim = 2; end
          else begin ref_dm[a] = d; exp_wdm = 2; end
          ref_pc    = ref_pc + 32'd4;
          exp_pulse = 1;
          exp_lat   = 4;
          exp.push_back(8'hAA);
        end else begin
          exp.push_back(8'hEE);
        end
      end
      8'h03: begin push_word(exp, ref_im[a]); exp_lat = 3; end
      8'h04: begin push_word(exp, ref_dm[a]); exp_lat = 3; end
      8'h05: begin push_word(exp, ref_rf[a % 32]); exp_lat = 3; end
      8'h06: begin
        if (ref_debug) begin
          ref_pc    = ref_pc + 32'd4;
          exp_pulse = 1;
          exp_lat   = 5;
          push_word(exp, ref_pc);
        end else begin
          exp.push_back(8'hEE);
        end
      end
      8'h07: begin ref_debug = 1'b0; exp.push_back(8'hAA); end
      8'h08: begin ref_debug = 1'b1; exp.push_back(8'hAA); end
      default: exp.push_back(8'hEE);
    endcase

    base = got_q.size();
    p0 = pulse_total; wi0 = we_im_cyc; wd0 = we_dm_cyc;
    hv0 = hold_viol; ev0 = excl_viol; lv0 = lddbg_viol;

    @(posedge clk);
    #1;
    foreach (cmd[i]) send_byte(cmd[i]);

    n = 0;
    stalled = 1'b0;
    while (got_q.size() < base + exp.size() && n < 400) begin
      @(negedge clk);
      n++;
      if (stall && !stalled && got_q.size() > base) begin
        force_stall = 1'b1;
        repeat (5) @(negedge clk);
        force_stall = 1'b0;
        stalled = 1'b1;
      end
    end
    repeat (4) @(negedge clk);

    $display("cmd %02h: %0d bytes sent, %0d resp bytes expected, %0d received",
             op, cmd.size(), exp.size(), got_q.size() - base);
    chk("resp_len", 32'(got_q.size() - base), 32'(exp.size()));
    foreach (exp[i]) begin
      if (base + i < got_q.size()) chk($sformatf("resp_byte%0d", i), 32'(got_q[base + i]), 32'(exp[i]));
    end
    chk("clk_ld_pulses", 32'(pulse_total - p0), 32'(exp_pulse));
    chk("we_im_cycles",  32'(we_im_cyc - wi0), 32'(exp_wim));
    chk("we_dm_cycles",  32'(we_dm_cyc - wd0), 32'(exp_wdm));
    chk("latency",       32'(first_tx_cyc - last_rx_cyc), 32'(exp_lat));
    chk("debug_mode",    32'(bus.debug), 32'(ref_debug));
    chk("tx_hold",       32'(hold_viol - hv0), 32'd0);
    chk("we_exclusive",  32'(excl_viol - ev0), 32'd0);
    chk("clk_ld_halted", 32'(lddbg_viol - lv0), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bq_t q;
    int  base, p0, wd0, nargs;
    logic [7:0] op;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_debug",    32'(bus.debug), 32'd1);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data), 32'd0);
    chk("rst_clk_ld",   32'(bus.clk_ld), 32'd0);
    chk("rst_addr",     bus.addr, 32'd0);
    chk("rst_din",      bus.din, 32'd0);
    chk("rst_we_im",    32'(bus.we_im), 32'd0);
    chk("rst_we_dm",    32'(bus.we_dm), 32'd0);

    for (int i = 0; i < 1024; i++) begin
      ref_im[i] = im[i];
      ref_dm[i] = dm[i];
    end
    for (int i = 0; i < 32; i++) ref_rf[i] = rf[i];
    ref_pc    = 32'd0;
    ref_debug = 1'b1;

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);

    // write then read back instruction memory
    q = {8'h01, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_cmd(q, 1'b0);
    chk("addr_hold", bus.addr, 32'h0000_0010);
    chk("din_hold",  bus.din,  32'h1234_5678);
    q = {8'h03, 8'h10, 8'h00};
    run_cmd(q, 1'b0);

    // top-of-range address, with a mid-stream stall on the read
    q = {8'h02, 8'hFF, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_cmd(q, 1'b0);
    q = {8'h04, 8'hFF, 8'h03};
    run_cmd(q, 1'b1);
    q = {8'h04, 8'hFF, 8'hFF};
    run_cmd(q, 1'b0);

    // rejected write while running
    q = {8'h07};
    run_cmd(q, 1'b0);
    q = {8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    run_cmd(q, 1'b0);
    q = {8'h06};
    run_cmd(q, 1'b0);
    q = {8'h08};
    run_cmd(q, 1'b0);

    // single step from a known pc
    pc_base    = 32'h1C00_0000;
    pulse_mark = pulse_total;
    ref_pc     = 32'h1C00_0000;
    q = {8'h06};
    run_cmd(q, 1'b0);
    q = {8'h55};
    run_cmd(q, 1'b0);

    // reset in the middle of a WDM
    base = got_q.size();
    p0   = pulse_total;
    wd0  = we_dm_cyc;
    @(posedge clk);
    #1;
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h99);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_debug",    32'(bus.debug), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_debug = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_pulses",   32'(pulse_total - p0), 32'd0);
    chk("midrst_we_dm",    32'(we_dm_cyc - wd0), 32'd0);
    chk("midrst_no_tx",    32'(got_q.size() - base), 32'd0);
    q = {8'h05, 8'h03, 8'h00};
    run_cmd(q, 1'b0);

    // random command mix
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = 8'h06;
        6: op = 8'h07;
        7: op = 8'h08;
        8: op = 8'(9 + $urandom_range(0, 200));
        default: op = 8'h00;
      endcase
      q = {op};
      nargs = (op == 8'h01 || op == 8'h02) ? 6 :
              (op == 8'h03 || op == 8'h04 || op == 8'h05) ? 2 : 0;
      for (int j = 0; j < nargs; j++) q.push_back(8'($urandom));
      run_cmd(q, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
